wave_loop_buffer: RTL and testbench
===================================

WAVE_LOOP_BUFFER -- requirements
Module: wave_loop_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning buffer depth in 256-bit words; power of two, at least 4.
REQ-002 SHALL have port clk, input, 1 bit: 250 MHz DAC-domain clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port s_axis_tdata, input, 256 bits: waveform words from the PS DMA stream.
REQ-005 SHALL have port s_axis_tvalid, input, 1 bit: load word valid.
REQ-006 SHALL have port s_axis_tready, output, 1 bit: load word accepted.
REQ-007 SHALL have port m_axis_tdata, output, 256 bits: head word, driven to the DAC controller.
REQ-008 SHALL have port m_axis_tvalid, output, 1 bit: buffer non-empty.
REQ-009 SHALL have port m_axis_tready, input, 1 bit: pop request from the DAC controller.
REQ-010 SHALL have port mux_sel, input, 1 bit: 0 = load, 1 = loop-back.
REQ-011 SHALL have port clear, input, 1 bit: synchronous flush pulse.
REQ-012 SHALL have port count, output, log2(DEPTH)+1 bits: current occupancy.
REQ-013 SHALL have port underrun, output, 1 bit: sticky flag, set on a pop request while empty.

Function
REQ-014 SHALL register mux_sel once. The mode of cycle N+1 is the mux_sel value sampled at edge N.
REQ-015 SHALL implement a state machine with states LOAD, LOOP and FLUSH:
- LOAD to LOOP when registered mux_sel = 1.
- LOOP to LOAD when registered mux_sel = 0.
- Any state to FLUSH on clear = 1.
- FLUSH to LOAD or LOOP, per registered mux_sel, on the next cycle.
REQ-016 SHALL present the word at the read pointer on m_axis_tdata first-word-fall-through, with m_axis_tvalid = (count != 0).
REQ-017 SHALL define a pop as m_axis_tvalid & m_axis_tready. A pop advances the read pointer by 1, modulo DEPTH.
REQ-018 In LOAD, SHALL drive s_axis_tready = (count < DEPTH). A push (s_axis_tvalid & s_axis_tready) writes the word at the write pointer and advances it modulo DEPTH.
REQ-019 In LOAD, a push and a pop in the same cycle SHALL leave count unchanged. Push alone increments count; pop alone decrements it.
REQ-020 In LOOP, SHALL hold s_axis_tready = 0. Each pop writes the popped word to the write pointer in the same cycle, so count is unchanged and the waveform recirculates indefinitely.
REQ-021 A word written into an empty buffer at edge N SHALL appear on m_axis_tdata with m_axis_tvalid = 1 from edge N+1 (write-to-valid latency 1 cycle).
REQ-022 When full in LOAD, SHALL deassert s_axis_tready combinationally. A pop in the same cycle does not reopen tready until the next cycle.
REQ-023 SHALL set underrun on any cycle with m_axis_tready = 1 and count = 0. underrun stays set until clear or reset. No pointer or count change on that cycle.
REQ-024 In FLUSH, SHALL zero both pointers, count and underrun, hold s_axis_tready = 0, and ignore pops. clear has priority over a simultaneous push or pop.
REQ-025 A mode change with data present SHALL preserve buffer contents and pointers; only the write source changes.
REQ-026 SHALL implement pointers with wrap at DEPTH-1 to 0 and count in log2(DEPTH)+1 bits. count never exceeds DEPTH and never underflows.
REQ-027 The memory SHALL infer block RAM or URAM; contents are not reset.

Reset
REQ-028 On rst = 0, SHALL asynchronously set the state per registered mux_sel = 0 (LOAD), both pointers = 0, count = 0, underrun = 0, m_axis_tvalid = 0 and s_axis_tready = 0.
REQ-029 On the first clk edge after rst rises, s_axis_tready SHALL become 1. Reset asserted mid-transfer discards all buffered words.

Verification
REQ-030 LOAD: push words 0x1..0x4, then hold m_axis_tready = 1 -> m_axis_tdata reads 0x1, 0x2, 0x3, 0x4 on consecutive cycles; count goes 4, 3, 2, 1, 0; m_axis_tvalid drops after the 4th pop.
REQ-031 Fill DEPTH words with tvalid held high -> s_axis_tready = 0 with count = DEPTH. Pop once -> tready = 1 one cycle later; the next push is accepted.
REQ-032 Load 3 words, set mux_sel = 1, pop for 9 cycles -> output sequence w0 w1 w2 w0 w1 w2 w0 w1 w2; count constant at 3; s_axis_tready = 0.
REQ-033 Empty buffer with m_axis_tready = 1 -> underrun = 1 next cycle and stays set. Pulse clear -> underrun = 0 and count = 0.
REQ-034 count = 5 with push, pop and clear asserted in one cycle -> count = 0 next cycle; the pushed word is discarded.
REQ-035 rst low for 1 cycle mid-LOOP with count = 8 -> count = 0, m_axis_tvalid = 0 and underrun = 0 immediately; after release with mux_sel = 0, s_axis_tready = 1.

Source files
------------

// File: rtl/wave_loop_buffer.sv
// Waveform loop buffer for the DAC path.
// LOAD mode fills the buffer from the PS DMA stream and drains it like a FIFO.
// LOOP mode writes every popped word back in behind the tail, so a loaded
// waveform is replayed indefinitely. A clear pulse flushes everything.
// The head word is presented first-word-fall-through on m_axis_*.

module wave_loop_buffer #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [255:0]             s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [255:0]             m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    input  logic                     mux_sel,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_LOOP  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          run_q;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          underrun_q, underrun_d;

    logic [255:0]  mem [DEPTH];
    logic [255:0]  ram_q;
    logic [255:0]  byp_data_q;
    logic          byp_sel_q;

    logic          flush;
    logic          in_load;
    logic          push;
    logic          pop;
    logic          recirc;
    logic          we;
    logic [255:0]  wdata;

    // Handshake and write-path decode.
    assign flush         = clear | (state_q == ST_FLUSH);
    assign in_load       = (state_q == ST_LOAD);
    assign m_axis_tvalid = (cnt_q != '0);
    // Ready depends on registered count, so a pop while full reopens it only
    // on the following cycle. run_q keeps it low until the first edge after reset.
    assign s_axis_tready = run_q & in_load & ~clear & (cnt_q != CNT_FULL);
    assign push          = s_axis_tvalid & s_axis_tready;
    assign pop           = m_axis_tvalid & m_axis_tready & ~flush;
    assign recirc        = pop & (state_q == ST_LOOP);
    assign we            = push | recirc;
    assign wdata         = recirc ? m_axis_tdata : s_axis_tdata;

    assign count    = cnt_q;
    assign underrun = underrun_q;

    // The state register is the single registered copy of mux_sel; clear
    // overrides it and forces one flush cycle.
    always_comb begin
        state_d = mux_sel ? ST_LOOP : ST_LOAD;
        if (clear) begin
            state_d = ST_FLUSH;
        end
    end

    // Pointer, occupancy and underrun next-state.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        underrun_d = underrun_q;
        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            cnt_d      = '0;
            underrun_d = 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (we) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            // Recirculation keeps count fixed; only LOAD-mode traffic moves it.
            if (push && !(pop && in_load)) begin
                cnt_d = cnt_q + CW'(1);
            end else if (!push && pop && in_load) begin
                cnt_d = cnt_q - CW'(1);
            end
            if (m_axis_tready && !m_axis_tvalid) begin
                underrun_d = 1'b1;
            end
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_LOAD;
            run_q      <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
        end
    end

    // Block RAM: synchronous read of the next head address (read-before-write).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr_q] <= wdata;
        end
        ram_q <= mem[rd_ptr_d];
    end

    // The RAM read is issued one cycle ahead at rd_ptr_d, so a write landing on
    // that same address this cycle would be missed; capture it here instead to
    // keep the one-cycle write-to-valid latency.
    always_ff @(posedge clk) begin
        byp_sel_q  <= we & (wr_ptr_q == rd_ptr_d);
        byp_data_q <= wdata;
    end

    // Head-word select between RAM output and same-address bypass.
    always_comb begin
        m_axis_tdata = byp_sel_q ? byp_data_q : ram_q;
    end

endmodule

// File: tb/tb_wave_loop_buffer.sv
// Directed self-checking bench for wave_loop_buffer with DEPTH = 8.
// A vector table covers FIFO load/drain, underrun and clear; hand-written
// sequences cover fill-to-full, loop recirculation and asynchronous reset.

module tb_wave_loop_buffer;

    localparam int DEPTH = 8;

    logic         clk;
    logic         rst;
    logic [255:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         mux_sel;
    logic         clear;
    logic [3:0]   count;
    logic         underrun;

    int checks = 0;
    int errors = 0;

    wave_loop_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .mux_sel       (mux_sel),
        .clear         (clear),
        .count         (count),
        .underrun      (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         sv;
        logic [255:0] sd;
        logic         mr;
        logic         ms;
        logic         clr;
        logic [3:0]   e_cnt;
        logic         e_mv;
        logic         e_sr;
        logic         chk_d;
        logic [255:0] e_md;
        logic         e_ur;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic sv, input logic [255:0] sd, input logic mr,
                                input logic ms, input logic clr, input logic [3:0] e_cnt,
                                input logic e_mv, input logic e_sr, input logic chk_d,
                                input logic [255:0] e_md, input logic e_ur);
        vec_t v;
        v.sv = sv; v.sd = sd; v.mr = mr; v.ms = ms; v.clr = clr;
        v.e_cnt = e_cnt; v.e_mv = e_mv; v.e_sr = e_sr; v.chk_d = chk_d;
        v.e_md = e_md; v.e_ur = e_ur;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [255:0] sd, input logic mr,
                         input logic ms, input logic clr);
        s_axis_tvalid = sv;
        s_axis_tdata  = sd;
        m_axis_tready = mr;
        mux_sel       = ms;
        clear         = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [255:0] lp [8];
    logic [255:0] w3 [3];

    initial begin
        // Table: inputs for the cycle, then expected outputs observed in it.
        vecs.push_back(mk(1, 'h1,  0, 0, 0, 0, 0, 1, 0, 0,    0));
        vecs.push_back(mk(1, 'h2,  0, 0, 0, 1, 1, 1, 1, 'h1,  0));
        vecs.push_back(mk(1, 'h3,  0, 0, 0, 2, 1, 1, 1, 'h1,  0));
        vecs.push_back(mk(1, 'h4,  0, 0, 0, 3, 1, 1, 1, 'h1,  0));
        vecs.push_back(mk(0, 0,    1, 0, 0, 4, 1, 1, 1, 'h1,  0));
        vecs.push_back(mk(0, 0,    1, 0, 0, 3, 1, 1, 1, 'h2,  0));
        vecs.push_back(mk(0, 0,    1, 0, 0, 2, 1, 1, 1, 'h3,  0));
        vecs.push_back(mk(0, 0,    1, 0, 0, 1, 1, 1, 1, 'h4,  0));
        vecs.push_back(mk(0, 0,    1, 0, 0, 0, 0, 1, 0, 0,    0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 0, 0, 1, 0, 0,    1));
        vecs.push_back(mk(0, 0,    1, 0, 0, 0, 0, 1, 0, 0,    1));
        vecs.push_back(mk(0, 0,    0, 0, 1, 0, 0, 0, 0, 0,    1));
        vecs.push_back(mk(0, 0,    0, 0, 0, 0, 0, 0, 0, 0,    0));
        vecs.push_back(mk(1, 'h11, 0, 0, 0, 0, 0, 1, 0, 0,    0));
        vecs.push_back(mk(1, 'h12, 0, 0, 0, 1, 1, 1, 1, 'h11, 0));
        vecs.push_back(mk(1, 'h13, 0, 0, 0, 2, 1, 1, 1, 'h11, 0));
        vecs.push_back(mk(1, 'h14, 0, 0, 0, 3, 1, 1, 1, 'h11, 0));
        vecs.push_back(mk(1, 'h15, 0, 0, 0, 4, 1, 1, 1, 'h11, 0));
        vecs.push_back(mk(1, 'h16, 1, 0, 1, 5, 1, 0, 1, 'h11, 0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 0, 0, 0, 0, 0,    0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 0, 0, 1, 0, 0,    0));
        vecs.push_back(mk(1, 'hAA, 0, 0, 0, 0, 0, 1, 0, 0,    0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1, 1, 1, 1, 'hAA, 0));

        // Reset state
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_count", 256'(count), 0);
        chk("rst_tvalid", 256'(m_axis_tvalid), 0);
        chk("rst_tready", 256'(s_axis_tready), 0);
        chk("rst_underrun", 256'(underrun), 0);
        rst = 1'b1;
        #1;
        chk("rel_tready_pre_edge", 256'(s_axis_tready), 0);
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].sv, vecs[i].sd, vecs[i].mr, vecs[i].ms, vecs[i].clr);
            #1;
            chk($sformatf("v%0d_count", i), 256'(count), 256'(vecs[i].e_cnt));
            chk($sformatf("v%0d_tvalid", i), 256'(m_axis_tvalid), 256'(vecs[i].e_mv));
            chk($sformatf("v%0d_tready", i), 256'(s_axis_tready), 256'(vecs[i].e_sr));
            chk($sformatf("v%0d_underrun", i), 256'(underrun), 256'(vecs[i].e_ur));
            if (vecs[i].chk_d) begin
                chk($sformatf("v%0d_tdata", i), m_axis_tdata, vecs[i].e_md);
            end
            tick();
        end

        // Fill to full, pop once while full, refill, drain with wrap.
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 256'('h100 + i), 0, 0, 0);
            #1;
            chk($sformatf("fill%0d_tready", i), 256'(s_axis_tready), 1);
            tick();
        end
        drive(1, 'h200, 0, 0, 0);
        #1;
        chk("full_count", 256'(count), 8);
        chk("full_tready", 256'(s_axis_tready), 0);
        tick();
        chk("full_hold_count", 256'(count), 8);
        drive(1, 'h200, 1, 0, 0);
        #1;
        chk("full_pop_tready", 256'(s_axis_tready), 0);
        chk("full_pop_head", m_axis_tdata, 'h100);
        tick();
        drive(1, 'h200, 0, 0, 0);
        #1;
        chk("after_pop_count", 256'(count), 7);
        chk("after_pop_tready", 256'(s_axis_tready), 1);
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("refill_count", 256'(count), 8);
        chk("refill_tready", 256'(s_axis_tready), 0);
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 1, 0, 0);
            #1;
            chk($sformatf("drain%0d_data", i), m_axis_tdata,
                (i < DEPTH - 1) ? 256'('h101 + i) : 256'('h200));
            tick();
        end
        drive(0, 0, 0, 0, 0);
        #1;
        chk("drained_count", 256'(count), 0);
        chk("drained_tvalid", 256'(m_axis_tvalid), 0);
        chk("drained_underrun", 256'(underrun), 0);

        // Loop: three words recirculate.
        for (int i = 0; i < 3; i++) begin
            w3[i] = 256'('hA0 + i);
            drive(1, w3[i], 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 1, 0);
        #1;
        chk("to_loop_tready", 256'(s_axis_tready), 1);
        tick();
        for (int k = 0; k < 9; k++) begin
            drive(1, 'hEE, 1, 1, 0);
            #1;
            chk($sformatf("loop%0d_data", k), m_axis_tdata, w3[k % 3]);
            chk($sformatf("loop%0d_count", k), 256'(count), 3);
            chk($sformatf("loop%0d_tready", k), 256'(s_axis_tready), 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        #1;
        chk("loop_exit_tready_pre", 256'(s_axis_tready), 0);
        tick();
        chk("load_again_tready", 256'(s_axis_tready), 1);
        chk("load_again_count", 256'(count), 3);
        chk("load_again_head", m_axis_tdata, w3[0]);

        // Full buffer in LOOP, then asynchronous reset mid-cycle.
        for (int i = 0; i < 3; i++) lp[i] = w3[i];
        for (int i = 3; i < 8; i++) begin
            lp[i] = 256'('hB0 + i);
            drive(1, lp[i], 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 1, 0);
        tick();
        chk("loop8_count", 256'(count), 8);
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 1, 1, 0);
            #1;
            chk($sformatf("loop8_%0d_data", k), m_axis_tdata, lp[k % 8]);
            chk($sformatf("loop8_%0d_count", k), 256'(count), 8);
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        chk("arst_count", 256'(count), 0);
        chk("arst_tvalid", 256'(m_axis_tvalid), 0);
        chk("arst_underrun", 256'(underrun), 0);
        chk("arst_tready", 256'(s_axis_tready), 0);
        drive(0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("arst_rel_tready_pre", 256'(s_axis_tready), 0);
        tick();
        chk("arst_rel_tready", 256'(s_axis_tready), 1);
        chk("arst_rel_count", 256'(count), 0);
        chk("arst_rel_tvalid", 256'(m_axis_tvalid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
